fsic_io_serdes_rx_link_ctrl: RTL and testbench

//  Link-bring-up controller for the IO-serdes receive lane, in the coreclk domain beside the rx deserializer.

---
 rtl/fsic_io_serdes_pkg.sv | 18 +
 rtl/fsic_io_serdes_rx_link_ctrl.sv | 178 +++++++++++++++++
 tb/tb_fsic_io_serdes_rx_link_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsic_io_serdes_pkg.sv
// Shared types for the IO-serdes receive link controller.
package fsic_io_serdes_pkg;

   localparam int unsigned RX_STATE_W = 3;
   localparam int unsigned RETRY_W    = 2;

   // Link bring-up states; encodings are visible on rx_state
   typedef enum logic [RX_STATE_W-1:0] {
      IDLE       = 3'd0,
      SETTLE     = 3'd1,
      WAIT_VALID = 3'd2,
      TRAIN      = 3'd3,
      LINK_UP    = 3'd4,
      BACKOFF    = 3'd5,
      FAIL       = 3'd6
   } rx_state_e;

endpackage

// File: rtl/fsic_io_serdes_rx_link_ctrl.sv
// Receive-lane bring-up: enable the deserializer, settle, train on a fixed
// pattern, then forward words; retry with backoff and latch failure.
module fsic_io_serdes_rx_link_ctrl
   import fsic_io_serdes_pkg::*;
#(
   parameter int unsigned           pCLK_RATIO   = 4,
   parameter int unsigned           pSETTLE_CYC  = 8,
   parameter int unsigned           pTIMEOUT_CYC = 256,
   parameter logic [pCLK_RATIO-1:0] pTRAIN_PAT   = pCLK_RATIO'(4'b1010),
   parameter int unsigned           pTRAIN_LEN   = 16,
   parameter int unsigned           pMAX_RETRY   = 3
) (
   input  logic                  coreclk,
   input  logic                  axis_rst_n,
   input  logic                  cfg_enable,
   input  logic                  cfg_retrain,
   input  logic [pCLK_RATIO-1:0] rxdata_in,
   input  logic                  rxdata_in_valid,
   output logic                  rxen,
   output logic                  rx_link_up,
   output logic                  rx_link_fail,
   output logic [RX_STATE_W-1:0] rx_state,
   output logic [RETRY_W-1:0]    rx_retry_cnt,
   output logic [pCLK_RATIO-1:0] rxdata_out,
   output logic                  rxdata_out_valid
);

   localparam int unsigned CNT_MAX = (pSETTLE_CYC > pTIMEOUT_CYC) ? pSETTLE_CYC : pTIMEOUT_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned MATCH_W = $clog2(pTRAIN_LEN + 1);

   rx_state_e               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [MATCH_W-1:0]      match_q, match_d;
   logic [RETRY_W-1:0]      retry_q, retry_d;
   logic                    rxen_q, rxen_d;
   logic                    up_q, up_d;
   logic                    fail_q, fail_d;
   logic [pCLK_RATIO-1:0]   dout_q, dout_d;
   logic                    dvld_q, dvld_d;
   logic                    inc_retry;
   logic                    word_match;
   logic                    train_done;
   logic                    cnt_zero;

   assign word_match = (rxdata_in == pTRAIN_PAT);
   assign train_done = word_match && (match_q == MATCH_W'(pTRAIN_LEN - 1));
   assign cnt_zero   = (cnt_q == '0);

   // State and registered outputs
   always_ff @(posedge coreclk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         match_q <= '0;
         retry_q <= '0;
         rxen_q  <= 1'b0;
         up_q    <= 1'b0;
         fail_q  <= 1'b0;
         dout_q  <= '0;
         dvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
         retry_q <= retry_d;
         rxen_q  <= rxen_d;
         up_q    <= up_d;
         fail_q  <= fail_d;
         dout_q  <= dout_d;
         dvld_q  <= dvld_d;
      end
   end

   // Next state, shared settle/timeout counter, training and retry bookkeeping
   always_comb begin
      state_d   = state_q;
      inc_retry = 1'b0;
      cnt_d     = cnt_q;
      match_d   = '0;
      retry_d   = retry_q;
      rxen_d    = 1'b0;
      up_d      = 1'b0;
      fail_d    = 1'b0;
      dout_d    = dout_q;
      dvld_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (cfg_enable) state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_zero) state_d = WAIT_VALID;
         end
         WAIT_VALID: begin
            if (rxdata_in_valid) begin
               state_d = TRAIN;
            end else if (cnt_zero) begin
               state_d   = BACKOFF;
               inc_retry = 1'b1;
            end
         end
         TRAIN: begin
            if (!rxdata_in_valid) begin
               state_d   = BACKOFF;
               inc_retry = 1'b1;
            end else if (train_done) begin
               state_d = LINK_UP;
            end else if (cnt_zero) begin
               state_d   = BACKOFF;
               inc_retry = 1'b1;
            end
         end
         LINK_UP: begin
            // Requested retrain is not counted as a failed attempt
            if (cfg_retrain) begin
               state_d = BACKOFF;
            end else if (!rxdata_in_valid) begin
               state_d   = BACKOFF;
               inc_retry = 1'b1;
            end
         end
         BACKOFF: begin
            if (cnt_zero) state_d = (32'(retry_q) < pMAX_RETRY) ? SETTLE : FAIL;
         end
         FAIL: begin
            if (cfg_retrain) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Disable wins over everything, including a retrain request
      if (!cfg_enable) begin
         state_d   = IDLE;
         inc_retry = 1'b0;
      end

      // Counter reloads on any state change and stops at zero
      if (state_d != state_q) begin
         case (state_d)
            SETTLE, BACKOFF:   cnt_d = CNT_W'(pSETTLE_CYC - 1);
            WAIT_VALID, TRAIN: cnt_d = CNT_W'(pTIMEOUT_CYC - 1);
            default:           cnt_d = '0;
         endcase
      end else if (!cnt_zero) begin
         cnt_d = cnt_q - CNT_W'(1);
      end

      // Mismatch only restarts the run: alignment may slip before lock
      if ((state_q == TRAIN) && (state_d == TRAIN) && word_match) begin
         match_d = match_q + MATCH_W'(1);
      end

      if (state_d == IDLE) begin
         retry_d = '0;
      end else if (inc_retry && (retry_q != '1)) begin
         retry_d = retry_q + RETRY_W'(1);
      end

      rxen_d = (state_d == SETTLE) || (state_d == WAIT_VALID) ||
               (state_d == TRAIN)  || (state_d == LINK_UP);
      up_d   = (state_d == LINK_UP);
      fail_d = (state_d == FAIL);

      // Forward only while the link stays up; data holds otherwise
      dvld_d = (state_q == LINK_UP) && (state_d == LINK_UP) && rxdata_in_valid;
      if (dvld_d) dout_d = rxdata_in;
   end

   assign rxen             = rxen_q;
   assign rx_link_up       = up_q;
   assign rx_link_fail     = fail_q;
   assign rx_state         = state_q;
   assign rx_retry_cnt     = retry_q;
   assign rxdata_out       = dout_q;
   assign rxdata_out_valid = dvld_q;

endmodule

// File: tb/tb_fsic_io_serdes_rx_link_ctrl.sv
// Directed bench for the receive link controller: vector table for the main
// lock/forward path, hand sequences for timeouts, retries and resets.
module tb_fsic_io_serdes_rx_link_ctrl;

   logic       coreclk = 1'b0;
   logic       axis_rst_n;
   logic       cfg_enable;
   logic       cfg_retrain;
   logic [3:0] rxdata_in;
   logic       rxdata_in_valid;
   logic       rxen;
   logic       rx_link_up;
   logic       rx_link_fail;
   logic [2:0] rx_state;
   logic [1:0] rx_retry_cnt;
   logic [3:0] rxdata_out;
   logic       rxdata_out_valid;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 coreclk = ~coreclk;

   fsic_io_serdes_rx_link_ctrl dut (
      .coreclk          (coreclk),
      .axis_rst_n       (axis_rst_n),
      .cfg_enable       (cfg_enable),
      .cfg_retrain      (cfg_retrain),
      .rxdata_in        (rxdata_in),
      .rxdata_in_valid  (rxdata_in_valid),
      .rxen             (rxen),
      .rx_link_up       (rx_link_up),
      .rx_link_fail     (rx_link_fail),
      .rx_state         (rx_state),
      .rx_retry_cnt     (rx_retry_cnt),
      .rxdata_out       (rxdata_out),
      .rxdata_out_valid (rxdata_out_valid)
   );

   typedef struct {
      logic       en;
      logic       vld;
      logic [3:0] din;
      logic [2:0] st;
      logic       up;
      logic       rxen;
      logic       ov;
      logic [3:0] dout;
      logic [1:0] rc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic en, input logic vld, input logic [3:0] din,
                      input logic [2:0] st, input logic up, input logic rx,
                      input logic ov, input logic [3:0] dout, input logic [1:0] rc);
      vec_t v;
      v.en = en; v.vld = vld; v.din = din; v.st = st; v.up = up;
      v.rxen = rx; v.ov = ov; v.dout = dout; v.rc = rc;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge coreclk);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] st, input int budget, input string name);
      int n;
      n = 0;
      while (rx_state != st && n < budget) begin
         step();
         n++;
      end
      chk(name, 32'(rx_state), 32'(st));
   endtask

   task automatic count_state(input logic [2:0] st, input int budget, output int n);
      n = 0;
      while (rx_state == st && n < budget) begin
         step();
         n++;
      end
   endtask

   task automatic lock(input string name);
      rxdata_in_valid = 1'b0;
      wait_state(3'd2, 64, {name, "_wv"});
      rxdata_in_valid = 1'b1;
      rxdata_in       = 4'hA;
      wait_state(3'd4, 64, {name, "_up"});
      chk({name, "_link"}, 32'(rx_link_up), 32'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      axis_rst_n      = 1'b1;
      cfg_enable      = 1'b0;
      cfg_retrain     = 1'b0;
      rxdata_in       = 4'h0;
      rxdata_in_valid = 1'b0;

      // Main path from the first WAIT_VALID cycle: train, lock, forward, drop valid
      for (int i = 0; i < 3; i++) add(1, 0, 4'h0, 3'd2, 0, 1, 0, 4'h0, 2'd0);
      add(1, 1, 4'h0, 3'd3, 0, 1, 0, 4'h0, 2'd0);
      for (int i = 0; i < 15; i++) add(1, 1, 4'hA, 3'd3, 0, 1, 0, 4'h0, 2'd0);
      add(1, 1, 4'hA, 3'd4, 1, 1, 0, 4'h0, 2'd0);
      add(1, 1, 4'h5, 3'd4, 1, 1, 1, 4'h5, 2'd0);
      add(1, 1, 4'hA, 3'd4, 1, 1, 1, 4'hA, 2'd0);
      add(1, 1, 4'h3, 3'd4, 1, 1, 1, 4'h3, 2'd0);
      add(1, 0, 4'h0, 3'd5, 0, 0, 0, 4'h3, 2'd1);

      #2 axis_rst_n = 1'b0;
      step();
      step();
      chk("rst_state", 32'(rx_state), 32'd0);
      chk("rst_rxen", 32'(rxen), 32'd0);
      chk("rst_outs", 32'({rx_link_up, rx_link_fail, rx_retry_cnt, rxdata_out, rxdata_out_valid}), 32'd0);
      axis_rst_n = 1'b1;
      step();
      chk("idle_hold", 32'(rx_state), 32'd0);

      cfg_enable = 1'b1;
      step();
      chk("t1_settle", 32'(rx_state), 32'd1);
      chk("t1_rxen", 32'(rxen), 32'd1);
      count_state(3'd1, 20, n);
      chk("t1_settle_len", 32'(n), 32'd8);
      chk("t1_wv", 32'(rx_state), 32'd2);

      for (int i = 0; i < tbl.size(); i++) begin
         cfg_enable      = tbl[i].en;
         rxdata_in_valid = tbl[i].vld;
         rxdata_in       = tbl[i].din;
         step();
         chk($sformatf("vec%0d_state", i), 32'(rx_state), 32'(tbl[i].st));
         chk($sformatf("vec%0d_up", i), 32'(rx_link_up), 32'(tbl[i].up));
         chk($sformatf("vec%0d_rxen", i), 32'(rxen), 32'(tbl[i].rxen));
         chk($sformatf("vec%0d_ov", i), 32'(rxdata_out_valid), 32'(tbl[i].ov));
         chk($sformatf("vec%0d_dout", i), 32'(rxdata_out), 32'(tbl[i].dout));
         chk($sformatf("vec%0d_rc", i), 32'(rx_retry_cnt), 32'(tbl[i].rc));
      end

      // Backoff holds rxen low for the settle time, then the retry relocks
      for (int i = 0; i < 7; i++) begin
         step();
         chk($sformatf("t4_bo%0d_state", i), 32'(rx_state), 32'd5);
         chk($sformatf("t4_bo%0d_rxen", i), 32'(rxen), 32'd0);
      end
      step();
      chk("t4_resettle", 32'(rx_state), 32'd1);
      chk("t4_resettle_rxen", 32'(rxen), 32'd1);
      chk("t4_rc", 32'(rx_retry_cnt), 32'd1);
      lock("t4");
      chk("t4_rc_after", 32'(rx_retry_cnt), 32'd1);

      // Disable in LINK_UP
      rxdata_in = 4'h7;
      step();
      chk("t6_fwd_ov", 32'(rxdata_out_valid), 32'd1);
      chk("t6_fwd_dout", 32'(rxdata_out), 32'h7);
      cfg_enable = 1'b0;
      step();
      chk("t6_up_state", 32'(rx_state), 32'd0);
      chk("t6_up_rxen", 32'(rxen), 32'd0);
      chk("t6_up_ov", 32'(rxdata_out_valid), 32'd0);
      chk("t6_up_link", 32'(rx_link_up), 32'd0);
      chk("t6_up_rc", 32'(rx_retry_cnt), 32'd0);
      chk("t6_up_dout_hold", 32'(rxdata_out), 32'h7);

      // Requested retrain does not count as a failure
      cfg_enable = 1'b1;
      lock("t5a");
      cfg_retrain = 1'b1;
      step();
      cfg_retrain = 1'b0;
      rxdata_in_valid = 1'b0;
      chk("t5_state", 32'(rx_state), 32'd5);
      chk("t5_rc", 32'(rx_retry_cnt), 32'd0);
      chk("t5_ov", 32'(rxdata_out_valid), 32'd0);
      chk("t5_rxen", 32'(rxen), 32'd0);
      lock("t5b");
      chk("t5_rc_after", 32'(rx_retry_cnt), 32'd0);

      // Mismatch mid-training restarts the match run
      cfg_enable = 1'b0;
      step();
      cfg_enable = 1'b1;
      rxdata_in_valid = 1'b0;
      wait_state(3'd2, 32, "t3_wv");
      rxdata_in_valid = 1'b1;
      rxdata_in = 4'hA;
      step();
      chk("t3_train", 32'(rx_state), 32'd3);
      for (int i = 0; i < 10; i++) step();
      rxdata_in = 4'h5;
      step();
      rxdata_in = 4'hA;
      for (int i = 0; i < 5; i++) step();
      chk("t3_16w", 32'(rx_state), 32'd3);
      for (int i = 0; i < 10; i++) step();
      chk("t3_26w", 32'(rx_state), 32'd3);
      chk("t3_26w_up", 32'(rx_link_up), 32'd0);
      step();
      chk("t3_27w", 32'(rx_state), 32'd4);
      chk("t3_27w_up", 32'(rx_link_up), 32'd1);

      // Training that never matches times out after 256 cycles
      cfg_enable = 1'b0;
      step();
      cfg_enable = 1'b1;
      rxdata_in_valid = 1'b0;
      wait_state(3'd2, 32, "tto_wv");
      rxdata_in_valid = 1'b1;
      rxdata_in = 4'h0;
      step();
      chk("tto_train", 32'(rx_state), 32'd3);
      count_state(3'd3, 300, n);
      chk("tto_len", 32'(n), 32'd256);
      chk("tto_state", 32'(rx_state), 32'd5);
      chk("tto_rc", 32'(rx_retry_cnt), 32'd1);

      // Disable in TRAIN
      cfg_enable = 1'b0;
      rxdata_in_valid = 1'b0;
      step();
      chk("t6_idle", 32'(rx_state), 32'd0);
      cfg_enable = 1'b1;
      wait_state(3'd2, 32, "t6_wv");
      rxdata_in_valid = 1'b1;
      rxdata_in = 4'hA;
      step();
      step();
      step();
      chk("t6_tr_pre", 32'(rx_state), 32'd3);
      cfg_enable = 1'b0;
      step();
      chk("t6_tr_state", 32'(rx_state), 32'd0);
      chk("t6_tr_rxen", 32'(rxen), 32'd0);
      chk("t6_tr_ov", 32'(rxdata_out_valid), 32'd0);

      // Valid never arrives: three timed-out attempts then FAIL
      cfg_enable = 1'b1;
      rxdata_in_valid = 1'b0;
      wait_state(3'd2, 32, "t2_wv");
      count_state(3'd2, 300, n);
      chk("t2_wv_len", 32'(n), 32'd256);
      chk("t2_bo", 32'(rx_state), 32'd5);
      chk("t2_rc1", 32'(rx_retry_cnt), 32'd1);
      wait_state(3'd6, 2000, "t2_fail_state");
      chk("t2_fail", 32'(rx_link_fail), 32'd1);
      chk("t2_rxen", 32'(rxen), 32'd0);
      chk("t2_rc3", 32'(rx_retry_cnt), 32'd3);
      step();
      chk("t2_fail_hold", 32'(rx_state), 32'd6);
      cfg_retrain = 1'b1;
      step();
      cfg_retrain = 1'b0;
      chk("t2_rt_idle", 32'(rx_state), 32'd0);
      chk("t2_rt_rc", 32'(rx_retry_cnt), 32'd0);
      chk("t2_rt_fail", 32'(rx_link_fail), 32'd0);
      step();
      chk("t2_rt_settle", 32'(rx_state), 32'd1);
      chk("t2_rt_rxen", 32'(rxen), 32'd1);
      lock("t2_relock");

      // Async reset mid-TRAIN clears everything without a clock edge
      cfg_enable = 1'b0;
      step();
      cfg_enable = 1'b1;
      rxdata_in_valid = 1'b0;
      wait_state(3'd2, 32, "tr_wv");
      rxdata_in_valid = 1'b1;
      rxdata_in = 4'hA;
      step();
      step();
      step();
      chk("tr_train", 32'(rx_state), 32'd3);
      chk("tr_dout_pre", 32'(rxdata_out), 32'h7);
      #2 axis_rst_n = 1'b0;
      #1;
      chk("tr_state", 32'(rx_state), 32'd0);
      chk("tr_rxen", 32'(rxen), 32'd0);
      chk("tr_outs", 32'({rx_link_up, rx_link_fail, rx_retry_cnt, rxdata_out, rxdata_out_valid}), 32'd0);
      #2 axis_rst_n = 1'b1;
      step();
      chk("tr_restart", 32'(rx_state), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
